// File: rtl/alu.sv
// rtl/alu.sv - registered rv32i execute-stage ALU with zero flag; optional ALU_EXT_FLAGS_EN adds neg/carry/ovf outputs
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] res,
    output logic             flag
`ifdef ALU_EXT_FLAGS_EN
    ,
    output logic             neg,
    output logic             carry,
    output logic             ovf
`endif
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    localparam int MSB = WIDTH - 1;

    // Shared adder: every op except ADD runs it as A + ~B + 1, so SUB,
    // SLT and SLTU all read their answer off the same subtraction.
    logic             sub_mode;
    logic [WIDTH-1:0] b_operand;
    logic [WIDTH:0]   adder_full;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_cout;
    logic             adder_ovf;
    logic             less_signed;
    logic             less_unsigned;
    logic [WIDTH-1:0] result_next;
    logic             zero_next;

    // Adder and comparison terms derived from the shared subtraction
    always_comb begin
        sub_mode   = (ALUControl != OP_ADD);
        b_operand  = sub_mode ? ~srcB : srcB;
        adder_full = {1'b0, srcA} + {1'b0, b_operand} + {{WIDTH{1'b0}}, sub_mode};
        adder_sum  = adder_full[WIDTH-1:0];
        adder_cout = adder_full[WIDTH];
        // Overflow when both adder inputs share a sign the sum does not.
        adder_ovf  = (srcA[MSB] == b_operand[MSB]) && (adder_sum[MSB] != srcA[MSB]);
        // Sign of the difference corrected by overflow gives signed less-than
        // even when A-B wraps (e.g. 0x80000000 - 1).
        less_signed   = adder_sum[MSB] ^ adder_ovf;
        // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
        less_unsigned = ~adder_cout;
    end

    // Result select; the reserved code yields zero so the flag reads 1
    always_comb begin
        result_next = '0;
        case (ALUControl)
            OP_ADD:  result_next = adder_sum;
            OP_SUB:  result_next = adder_sum;
            OP_AND:  result_next = srcA & srcB;
            OP_OR:   result_next = srcA | srcB;
            OP_XOR:  result_next = srcA ^ srcB;
            OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, less_signed};
            OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, less_unsigned};
            default: result_next = '0;
        endcase
        // Zero flag comes from the very value being captured this edge.
        zero_next = (result_next == '0);
    end

    // Result and zero flag register: reset wins over enable, en=0 holds
    always_ff @(posedge clk) begin
        if (reset) begin
            res  <= '0;
            flag <= 1'b0;
        end else if (en) begin
            res  <= result_next;
            flag <= zero_next;
        end
    end

`ifdef ALU_EXT_FLAGS_EN
    logic is_arith;
    logic carry_next;
    logic ovf_next;

    // Carry and overflow only mean something for ADD and SUB
    always_comb begin
        is_arith   = (ALUControl == OP_ADD) || (ALUControl == OP_SUB);
        carry_next = is_arith ? adder_cout : 1'b0;
        ovf_next   = is_arith ? adder_ovf  : 1'b0;
    end

    // Extended flag register, same reset/enable behaviour as the result
    always_ff @(posedge clk) begin
        if (reset) begin
            neg   <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (en) begin
            neg   <= result_next[MSB];
            carry <= carry_next;
            ovf   <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu (vector table, directed corners, random vs. reference model)
module tb_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic [2:0]   ALUControl;
    logic [W-1:0] res;
    logic         flag;
`ifdef ALU_EXT_FLAGS_EN
    logic         neg;
    logic         carry;
    logic         ovf;
`endif

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .srcA(srcA),
        .srcB(srcB),
        .ALUControl(ALUControl),
        .res(res),
        .flag(flag)
`ifdef ALU_EXT_FLAGS_EN
        ,
        .neg(neg),
        .carry(carry),
        .ovf(ovf)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Expected registered state kept by the bench
    logic [W-1:0] exp_res;
    logic         exp_flag;
    logic [2:0]   exp_ext;   // {neg, carry, ovf}

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] r;
        logic         f;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic [W-1:0] r, input logic f);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.r = r; v.f = f;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, want);
        end
    endtask

    // Reference result from the arithmetic definition of each op
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
            3'd6: return (a < b) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // Reference {neg, carry, ovf} from wide integer arithmetic
    function automatic logic [2:0] ref_ext(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        longint s;
        logic   c;
        logic   o;
        c = 1'b0;
        o = 1'b0;
        if (op == 3'd0) begin
            c = ((64'(a) + 64'(b)) >= 64'h1_0000_0000);
            s = longint'($signed(a)) + longint'($signed(b));
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 3'd1) begin
            c = (a >= b);
            s = longint'($signed(a)) - longint'($signed(b));
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {ref_res(a, b, op) >= 32'h8000_0000, c, o};
    endfunction

    task automatic model_capture(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_res  = ref_res(a, b, op);
        exp_flag = (exp_res == 0);
        exp_ext  = ref_ext(a, b, op);
    endtask

    task automatic model_reset();
        exp_res  = '0;
        exp_flag = 1'b0;
        exp_ext  = 3'b000;
    endtask

    task automatic check_outputs(input string name);
        check({name, ".res"}, res, exp_res);
        check({name, ".flag"}, 32'(flag), 32'(exp_flag));
`ifdef ALU_EXT_FLAGS_EN
        check({name, ".ext"}, 32'({neg, carry, ovf}), 32'(exp_ext));
`endif
    endtask

    // Drive at the negedge we're on, let one rising edge pass, return at next negedge
    task automatic cycle(input logic r, input logic e, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op);
        reset = r; en = e; srcA = a; srcB = b; ALUControl = op;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; srcA = 32'h1234_5678; srcB = 32'h0F0F_0F0F; ALUControl = 3'd0;
        model_reset();

        // Table of directed vectors
        for (int op = 0; op < 7; op++) add_vec(32'h401, 32'h401, 3'(op),
            (op == 0) ? 32'h802 : (op == 2 || op == 3) ? 32'h401 : 32'h0,
            !(op == 0 || op == 2 || op == 3));
        add_vec(32'h401, 32'h3E8, 3'd0, 32'h7E9, 1'b0);
        add_vec(32'h401, 32'h3E8, 3'd1, 32'h19,  1'b0);
        add_vec(32'h401, 32'h3E8, 3'd2, 32'h0,   1'b1);
        add_vec(32'h401, 32'h3E8, 3'd3, 32'h7E9, 1'b0);
        add_vec(32'h401, 32'h3E8, 3'd4, 32'h7E9, 1'b0);
        add_vec(32'h401, 32'h3E8, 3'd5, 32'h0,   1'b1);
        add_vec(32'h201, 32'h3E8, 3'd0, 32'h5E9, 1'b0);
        add_vec(32'h201, 32'h3E8, 3'd1, 32'hFFFF_FE19, 1'b0);
        add_vec(32'h201, 32'h3E8, 3'd2, 32'h200, 1'b0);
        add_vec(32'h201, 32'h3E8, 3'd3, 32'h3E9, 1'b0);
        add_vec(32'h201, 32'h3E8, 3'd4, 32'h1E9, 1'b0);
        add_vec(32'h201, 32'h3E8, 3'd5, 32'h1,   1'b0);
        add_vec(32'hFFFF_FFFF, 32'h1, 3'd5, 32'h1, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'h1, 3'd6, 32'h0, 1'b1);
        add_vec(32'h8000_0000, 32'h1, 3'd5, 32'h1, 1'b0);
        add_vec(32'h8000_0000, 32'h1, 3'd6, 32'h0, 1'b1);
        add_vec(32'h1, 32'h8000_0000, 3'd5, 32'h0, 1'b1);
        add_vec(32'h1, 32'h8000_0000, 3'd6, 32'h1, 1'b0);
        add_vec(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h8000_0000, 1'b0);
        add_vec(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'd7, 32'h0, 1'b1);
        add_vec(32'h0, 32'h0, 3'd7, 32'h0, 1'b1);
        add_vec(32'hFFFF_FFFF, 32'h1, 3'd0, 32'h0, 1'b1);

        // Reset held two edges with en=1 and live operands
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 32'($urandom), 32'($urandom), 3'd3);
            model_reset();
            check_outputs("reset");
        end

        // Directed table, captured one edge after each drive
        foreach (tbl[i]) begin
            cycle(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].op);
            check($sformatf("vec%0d.res", i), res, tbl[i].r);
            check($sformatf("vec%0d.flag", i), 32'(flag), 32'(tbl[i].f));
            model_capture(tbl[i].a, tbl[i].b, tbl[i].op);
        end

        // Hold for three cycles while inputs wander, then re-enable
        cycle(1'b0, 1'b1, 32'h0000_1234, 32'h0000_0034, 3'd1);
        model_capture(32'h0000_1234, 32'h0000_0034, 3'd1);
        check_outputs("hold_pre");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'($urandom), 32'($urandom), 3'($urandom_range(0, 7)));
            check_outputs($sformatf("hold%0d", i));
        end
        reset = 1'b0; en = 1'b1; srcA = 32'h10; srcB = 32'h10; ALUControl = 3'd1;
        #1;
        check_outputs("no_comb_path");
        @(posedge clk);
        @(negedge clk);
        model_capture(32'h10, 32'h10, 3'd1);
        check("latency.res", res, 32'h0);
        check("latency.flag", 32'(flag), 32'h1);

        // Reset mid-stream discards the pending capture, also with en=0
        cycle(1'b0, 1'b1, 32'h5, 32'h7, 3'd0);
        model_capture(32'h5, 32'h7, 3'd0);
        check_outputs("pre_reset");
        cycle(1'b1, 1'b1, 32'h9, 32'h9, 3'd0);
        model_reset();
        check_outputs("reset_mid");
        cycle(1'b0, 1'b1, 32'h9, 32'h9, 3'd4);
        model_capture(32'h9, 32'h9, 3'd4);
        check_outputs("post_reset");
        cycle(1'b0, 1'b1, 32'h9, 32'h2, 3'd0);
        model_capture(32'h9, 32'h2, 3'd0);
        cycle(1'b1, 1'b0, 32'h9, 32'h2, 3'd0);
        model_reset();
        check_outputs("reset_over_en");

`ifdef ALU_EXT_FLAGS_EN
        cycle(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1, 3'd0);
        check("ext_ovf.res", res, 32'h8000_0000);
        check("ext_ovf.nco", 32'({neg, carry, ovf}), 32'b101);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 3'd0);
        check("ext_carry.res", res, 32'h0);
        check("ext_carry.flag", 32'(flag), 32'h1);
        check("ext_carry.nco", 32'({neg, carry, ovf}), 32'b010);
        model_capture(32'hFFFF_FFFF, 32'h1, 3'd0);
`endif

        // Random operands, ops and enable against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [2:0]   op;
            logic         e;
            logic         r;
            a  = 32'($urandom);
            b  = 32'($urandom);
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'h8000_0000;
                2: b = 32'h7FFF_FFFF;
                3: a = 32'($urandom_range(0, 3));
                default: ;
            endcase
            op = 3'($urandom_range(0, 7));
            e  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 39) == 0);
            cycle(r, e, a, b, op);
            if (r) model_reset();
            else if (e) model_capture(a, b, op);
            check_outputs($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer ALU for the rv32i datapath execute stage.
- Computes one of eight operations on srcA/srcB selected by ALUControl.
- Registers the result and a zero flag on the rising clock edge; flag feeds branch decision logic.
- Fixed one-cycle latency, no back-pressure.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when low, res and flag hold.
- srcA  input  WIDTH  operand A.
- srcB  input  WIDTH  operand B.
- ALUControl  input  3  operation select.
- res  output  WIDTH  registered result.
- flag  output  1  registered zero flag; 1 when the captured result equals 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: on a rising edge with reset=1, res←0 and flag←0. This overrides en.
- Reset mid-stream: a pending computation is discarded.
- Capture: on a rising edge with reset=0 and en=1, res←f(srcA,srcB,ALUControl) and flag←(f==0).
- Latency: exactly 1 cycle; no combinational input-to-output path.
- Hold: with en=0, res and flag keep their values indefinitely.
- Operation encodings (ALUControl):
  - 000 ADD: A+B modulo 2^WIDTH; carry discarded.
  - 001 SUB: A−B modulo 2^WIDTH, two's complement (A + ~B + 1).
  - 010 AND: bitwise.
  - 011 OR: bitwise.
  - 100 XOR: bitwise.
  - 101 SLT: 1 if signed(A) < signed(B), else 0, zero-extended to WIDTH.
  - 110 SLTU: 1 if unsigned(A) < unsigned(B), else 0, zero-extended.
  - 111 reserved: result 0, so flag=1.
- SLT must be correct on signed overflow: use the sign of the subtraction XOR overflow (e.g. A=0x80000000, B=1 gives 1).
- Equal operands: SUB gives 0 (flag=1); SLT and SLTU give 0.
- flag is derived from the same result value that is captured, never from a stale one.
- X/undefined ALUControl values must not occur after reset; the reserved code is handled as stated.

Optional Feature:
- Macro ALU_EXT_FLAGS_EN.
- When defined, adds three registered outputs, all cleared by reset and held when en=0:
  - neg (1): MSB of the result.
  - carry (1): carry-out of ADD, or NOT borrow of SUB; 0 for all other ops.
  - ovf (1): signed overflow of ADD/SUB; 0 for all other ops.
- When undefined, these ports and their logic are absent; res/flag behaviour is identical in both builds.

Test Plan:
- Reset: hold reset=1 for 2 edges with en=1 and arbitrary operands -> res=0, flag=0. Then release; first en=1 edge captures normally.
- A=B=1025 (0x401), ops 000..101 -> ADD 0x802 f0; SUB 0 f1; AND 0x401 f0; OR 0x401 f0; XOR 0 f1; SLT 0 f1.
- A=1025, B=1000 (0x3E8) -> ADD 0x7E9 (2025) f0; SUB 0x19 (25) f0; AND 0 f1; OR 0x7E9 f0; XOR 0x7E9 f0; SLT 0 f1.
- A=513 (0x201), B=1000 -> ADD 0x5E9 (1513); SUB 0xFFFFFE19 f0; AND 0x200; OR 0x3E9; XOR 0x1E9; SLT 1 f0.
- Signed/unsigned split: A=0xFFFFFFFF, B=1 -> SLT=1, SLTU=0 (flag=1). A=0x80000000, B=1 -> SLT=1. ALUControl=111 -> res=0, flag=1.
- Enable/latency: change inputs with en=0 for 3 cycles -> res/flag unchanged. Raise en -> new result appears exactly one edge later.
- With ALU_EXT_FLAGS_EN: 0x7FFFFFFF+1 -> ovf=1, neg=1, carry=0. 0xFFFFFFFF+1 -> carry=1, res=0, flag=1.
